// File: rtl/fas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fas_pkg
//  Description : Shared types and constants for the FAS analysis datapath.
//                FFT frame geometry, complex bin type, magnitude type and the
//                peak-analyzer FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fas_pkg;

   localparam int FFT_POINTS = 16;   // bins per frame
   localparam int FFT_DW     = 16;   // width of one real/imag component
   localparam int MAG_W      = 32;   // width of re^2 + im^2
   localparam int IDX_W      = 4;    // log2(FFT_POINTS)
   localparam int PAIR_W     = 3;    // log2(FFT_POINTS/2)

   // One FFT bin; packed so that re sits in [31:16] and im in [15:0].
   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   typedef logic [MAG_W-1:0] mag_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : fas_pkg
`default_nettype wire

// File: rtl/fas_mag2.sv
`default_nettype none
// ============================================================================
//  Module      : fas_mag2
//  Description : Combinational squared magnitude of one complex bin,
//                mag = re*re + im*im.
//  Ports       : sample - complex input bin (signed re/im)
//                mag    - unsigned squared magnitude
//  Revision    : 1.0 - initial release
// ============================================================================
module fas_mag2
   import fas_pkg::*;
(
   input  cplx_t sample,
   output mag_t  mag
);

   logic signed [MAG_W-1:0] re_ext;
   logic signed [MAG_W-1:0] im_ext;
   logic signed [MAG_W-1:0] re_sq;
   logic signed [MAG_W-1:0] im_sq;

   // Squares are formed signed: the largest is (-32768)^2 = 2^30, so each
   // fits a positive 32-bit value and their sum (<= 2^31) never wraps as
   // an unsigned 32-bit quantity.
   always_comb begin
      re_ext = {{(MAG_W-FFT_DW){sample.re[FFT_DW-1]}}, sample.re};
      im_ext = {{(MAG_W-FFT_DW){sample.im[FFT_DW-1]}}, sample.im};
      re_sq  = re_ext * re_ext;
      im_sq  = im_ext * im_ext;
      mag    = $unsigned(re_sq) + $unsigned(im_sq);
   end

endmodule : fas_mag2
`default_nettype wire

// File: rtl/fas_peak_analyzer.sv
`default_nettype none
// ============================================================================
//  Module      : fas_peak_analyzer
//  Description : Captures a 16-bin FFT frame, scans it two bins per cycle
//                for the largest |X[k]|^2 and reports the winning bin index.
//  Ports       : clk        - clock, rising edge
//                rst        - synchronous active-high reset
//                fft_valid  - frame strobe, fft_d0..fft_d15 valid this cycle
//                fft_d0..15 - bin k, [31:16] re, [15:0] im, signed
//                done       - one-cycle pulse, freq updated this cycle
//                freq       - index of the strongest bin (held)
//                busy       - frame captured and being scanned
//                overrun    - sticky, a frame arrived during a scan
//  Revision    : 1.0 - initial release
// ============================================================================
module fas_peak_analyzer
   import fas_pkg::*;
#(
   parameter bit SKIP_DC = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fft_valid,
   input  logic [2*FFT_DW-1:0]   fft_d0,
   input  logic [2*FFT_DW-1:0]   fft_d1,
   input  logic [2*FFT_DW-1:0]   fft_d2,
   input  logic [2*FFT_DW-1:0]   fft_d3,
   input  logic [2*FFT_DW-1:0]   fft_d4,
   input  logic [2*FFT_DW-1:0]   fft_d5,
   input  logic [2*FFT_DW-1:0]   fft_d6,
   input  logic [2*FFT_DW-1:0]   fft_d7,
   input  logic [2*FFT_DW-1:0]   fft_d8,
   input  logic [2*FFT_DW-1:0]   fft_d9,
   input  logic [2*FFT_DW-1:0]   fft_d10,
   input  logic [2*FFT_DW-1:0]   fft_d11,
   input  logic [2*FFT_DW-1:0]   fft_d12,
   input  logic [2*FFT_DW-1:0]   fft_d13,
   input  logic [2*FFT_DW-1:0]   fft_d14,
   input  logic [2*FFT_DW-1:0]   fft_d15,
   output logic                  done,
   output logic [IDX_W-1:0]      freq,
   output logic                  busy,
   output logic                  overrun
);

   // ------------------------------------------------------------------
   // Input bins as complex values
   // ------------------------------------------------------------------
   cplx_t fft_in [FFT_POINTS];

   assign fft_in[0]  = cplx_t'(fft_d0);
   assign fft_in[1]  = cplx_t'(fft_d1);
   assign fft_in[2]  = cplx_t'(fft_d2);
   assign fft_in[3]  = cplx_t'(fft_d3);
   assign fft_in[4]  = cplx_t'(fft_d4);
   assign fft_in[5]  = cplx_t'(fft_d5);
   assign fft_in[6]  = cplx_t'(fft_d6);
   assign fft_in[7]  = cplx_t'(fft_d7);
   assign fft_in[8]  = cplx_t'(fft_d8);
   assign fft_in[9]  = cplx_t'(fft_d9);
   assign fft_in[10] = cplx_t'(fft_d10);
   assign fft_in[11] = cplx_t'(fft_d11);
   assign fft_in[12] = cplx_t'(fft_d12);
   assign fft_in[13] = cplx_t'(fft_d13);
   assign fft_in[14] = cplx_t'(fft_d14);
   assign fft_in[15] = cplx_t'(fft_d15);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   cplx_t               frame_q [FFT_POINTS];
   cplx_t               frame_d [FFT_POINTS];
   logic [PAIR_W-1:0]   pair_q, pair_d;
   mag_t                max_q, max_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [IDX_W-1:0]    freq_q, freq_d;
   logic                overrun_q, overrun_d;

   // ------------------------------------------------------------------
   // Pair datapath: bins 2p and 2p+1 evaluated together
   // ------------------------------------------------------------------
   logic [IDX_W-1:0]    even_idx;
   logic [IDX_W-1:0]    odd_idx;
   cplx_t               even_bin;
   cplx_t               odd_bin;
   mag_t                even_mag_raw;
   mag_t                even_mag;
   mag_t                odd_mag;
   mag_t                step_max;
   logic [IDX_W-1:0]    step_idx;
   logic                capture;
   logic                last_pair;

   assign even_idx = {pair_q, 1'b0};
   assign odd_idx  = {pair_q, 1'b1};
   assign even_bin = frame_q[even_idx];
   assign odd_bin  = frame_q[odd_idx];

   fas_mag2 u_mag_even (
      .sample (even_bin),
      .mag    (even_mag_raw)
   );

   fas_mag2 u_mag_odd (
      .sample (odd_bin),
      .mag    (odd_mag)
   );

   // DC suppression: bin 0 only ever appears as the even bin of pair 0.
   assign even_mag = (SKIP_DC && (pair_q == '0)) ? '0 : even_mag_raw;

   // Strictly-greater updates, even bin first, so ties keep the lower index.
   always_comb begin
      step_max = max_q;
      step_idx = idx_q;
      if (even_mag > step_max) begin
         step_max = even_mag;
         step_idx = even_idx;
      end
      if (odd_mag > step_max) begin
         step_max = odd_mag;
         step_idx = odd_idx;
      end
   end

   // A frame is taken whenever no scan is in flight (IDLE or DONE).
   assign capture   = fft_valid && (state_q != SCAN);
   assign last_pair = (pair_q == {PAIR_W{1'b1}});

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fft_valid) state_d = SCAN;
         SCAN:    if (last_pair) state_d = DONE;
         DONE:    state_d = fft_valid ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs (all from registers, no input-to-output path)
   // ------------------------------------------------------------------
   always_comb begin
      busy    = (state_q == SCAN);
      done    = (state_q == DONE);
      freq    = freq_q;
      overrun = overrun_q;
   end

   // ------------------------------------------------------------------
   // Datapath next-state
   // ------------------------------------------------------------------
   always_comb begin
      frame_d   = frame_q;
      pair_d    = pair_q;
      max_d     = max_q;
      idx_d     = idx_q;
      freq_d    = freq_q;
      overrun_d = overrun_q;

      if (capture) begin
         frame_d = fft_in;
         pair_d  = '0;
         max_d   = '0;
         idx_d   = '0;
      end else if (state_q == SCAN) begin
         pair_d = pair_q + 1'b1;
         max_d  = step_max;
         idx_d  = step_idx;
         if (last_pair) begin
            freq_d = step_idx;
         end
      end

      // A frame arriving mid-scan is dropped; the flag stays until reset.
      if ((state_q == SCAN) && fft_valid) begin
         overrun_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_q    <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         freq_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         pair_q    <= pair_d;
         max_q     <= max_d;
         idx_q     <= idx_d;
         freq_q    <= freq_d;
         overrun_q <= overrun_d;
      end
   end

   // The frame store is only read while scanning, after a capture has
   // overwritten it, so it carries no reset.
   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

endmodule : fas_peak_analyzer
`default_nettype wire
